// File: rtl/pipelined_barrel_shifter_if.sv
// rtl/pipelined_barrel_shifter_if.sv - stream handshake bundle for the pipelined barrel shifter
//
// Ports (signals):
//   in_valid/in_ready   input beat handshake
//   data_in             operand, WIDTH bits
//   shift_amt           shift/rotate amount, $clog2(WIDTH) bits
//   left_right          1 = left, 0 = right
//   mode                00 logical, 01 arithmetic, 10 rotate, 11 logical
//   out_valid/out_ready result beat handshake
//   data_out            result, WIDTH bits
//   busy                any stage holds a beat
// Modports: master = producer/consumer side, slave = shifter side.

interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shift_amt;
    logic             left_right;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             busy;

    modport master (
        output in_valid, data_in, shift_amt, left_right, mode, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, shift_amt, left_right, mode, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined logical/arithmetic/rotate shifter with elastic stages
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; drops every in-flight beat
//   bus    pipelined_barrel_shifter_if.slave (input/output stream, busy)
// The log2(WIDTH) shift levels are spread over PIPE_STAGES register
// stages; each stage is a 1-entry elastic slot carrying data plus the
// side-band (amount, direction, mode) the later levels still need.

module pipelined_barrel_shifter #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    pipelined_barrel_shifter_if.slave        bus
);
    localparam int L   = $clog2(WIDTH);
    localparam int SHW = L;
    localparam int LPS = (L + PIPE_STAGES - 1) / PIPE_STAGES;

    logic [PIPE_STAGES-1:0] r_valid;
    logic [WIDTH-1:0]       r_data [PIPE_STAGES];
    logic [SHW-1:0]         r_amt  [PIPE_STAGES];
    logic                   r_lr   [PIPE_STAGES];
    logic [1:0]             r_mode [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] w_advance;
    logic [PIPE_STAGES-1:0] w_src_valid;
    logic [WIDTH-1:0]       w_src_data  [PIPE_STAGES];
    logic [SHW-1:0]         w_src_amt   [PIPE_STAGES];
    logic                   w_src_lr    [PIPE_STAGES];
    logic [1:0]             w_src_mode  [PIPE_STAGES];
    logic [WIDTH-1:0]       w_next_data [PIPE_STAGES];

    // One level: move by 2^k in the requested direction/mode.
    // Arithmetic right keeps the MSB, so applying it level by level
    // still fills with the original operand's sign bit.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input int               k,
        input logic             lr,
        input logic [1:0]       md
    );
        int                      n;
        logic [WIDTH-1:0]        r;
        logic signed [WIDTH-1:0] sd;
        n  = 1 << k;
        sd = d;
        r  = d;
        if (md == 2'b10) begin
            if (lr) r = (d << n) | (d >> (WIDTH - n));
            else    r = (d >> n) | (d << (WIDTH - n));
        end else if (lr) begin
            r = d << n;
        end else if (md == 2'b01) begin
            r = sd >>> n;
        end else begin
            r = d >> n;
        end
        return r;
    endfunction

    // A stage may load when it, or any stage downstream of it, is empty,
    // or the consumer takes the last beat: bubbles collapse.
    always_comb begin
        w_advance = '0;
        for (int s = 0; s < PIPE_STAGES; s++) begin
            w_advance[s] = bus.out_ready;
            for (int j = s; j < PIPE_STAGES; j++) begin
                if (!r_valid[j]) w_advance[s] = 1'b1;
            end
        end
    end

    // Stage inputs: stage 0 from the bus, others from the previous slot.
    always_comb begin
        w_src_valid[0] = bus.in_valid;
        w_src_data[0]  = bus.data_in;
        w_src_amt[0]   = bus.shift_amt;
        w_src_lr[0]    = bus.left_right;
        w_src_mode[0]  = bus.mode;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            w_src_valid[s] = r_valid[s-1];
            w_src_data[s]  = r_data[s-1];
            w_src_amt[s]   = r_amt[s-1];
            w_src_lr[s]    = r_lr[s-1];
            w_src_mode[s]  = r_mode[s-1];
        end
    end

    // Level k belongs to stage k / LPS.
    always_comb begin
        for (int s = 0; s < PIPE_STAGES; s++) begin
            w_next_data[s] = w_src_data[s];
            for (int k = 0; k < L; k++) begin
                if ((k / LPS) == s && w_src_amt[s][k]) begin
                    w_next_data[s] = shift_level(w_next_data[s], k, w_src_lr[s], w_src_mode[s]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_data[s] <= '0;
                r_amt[s]  <= '0;
                r_lr[s]   <= 1'b0;
                r_mode[s] <= 2'b00;
            end
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                if (w_advance[s]) begin
                    r_valid[s] <= w_src_valid[s];
                    if (w_src_valid[s]) begin
                        r_data[s] <= w_next_data[s];
                        r_amt[s]  <= w_src_amt[s];
                        r_lr[s]   <= w_src_lr[s];
                        r_mode[s] <= w_src_mode[s];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = !reset && w_advance[0];
    assign bus.out_valid = r_valid[PIPE_STAGES-1];
    assign bus.data_out  = r_data[PIPE_STAGES-1];
    assign bus.busy      = |r_valid;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - self-checking bench for pipelined_barrel_shifter

module tb_pipelined_barrel_shifter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(32)) if32 ();
    pipelined_barrel_shifter_if #(.WIDTH(16)) if16 ();

    pipelined_barrel_shifter #(.WIDTH(32), .PIPE_STAGES(5)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (if32)
    );

    pipelined_barrel_shifter #(.WIDTH(16), .PIPE_STAGES(1)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16)
    );

    int errors = 0;
    int checks = 0;

    // Whole-amount reference: w-bit operand, result zero-extended to 64 bits.
    function automatic logic [63:0] ref_shift(input int w, input logic [63:0] d_in,
                                              input int amt, input logic lr, input logic [1:0] md);
        logic [63:0] mask, d, r;
        mask = (64'd1 << w) - 64'd1;
        d    = d_in & mask;
        if (md == 2'b10) begin
            r = lr ? ((d << amt) | (d >> (w - amt))) : ((d >> amt) | (d << (w - amt)));
        end else if (lr) begin
            r = d << amt;
        end else begin
            r = d >> amt;
            if (md == 2'b01 && d[w-1]) r = r | (mask & ~(mask >> amt));
        end
        return r & mask;
    endfunction

    task automatic drive(input bit s16, input logic v, input logic [31:0] d, input int amt,
                         input logic lr, input logic [1:0] md, input logic ordy);
        if (s16) begin
            if16.in_valid = v; if16.data_in = d[15:0]; if16.shift_amt = 4'(amt);
            if16.left_right = lr; if16.mode = md; if16.out_ready = ordy;
        end else begin
            if32.in_valid = v; if32.data_in = d; if32.shift_amt = 5'(amt);
            if32.left_right = lr; if32.mode = md; if32.out_ready = ordy;
        end
    endtask

    function automatic logic in_rdy(input bit s16);
        return s16 ? if16.in_ready : if32.in_ready;
    endfunction
    function automatic logic out_vld(input bit s16);
        return s16 ? if16.out_valid : if32.out_valid;
    endfunction
    function automatic logic [31:0] out_dat(input bit s16);
        return s16 ? {16'h0, if16.data_out} : if32.data_out;
    endfunction

    // Send one beat with out_ready high; report latency (-1 on timeout) and result.
    task automatic xfer(input bit s16, input logic [31:0] d, input int amt, input logic lr,
                        input logic [1:0] md, output int lat, output logic [31:0] res);
        int w;
        lat = -1;
        res = '0;
        w   = 0;
        @(negedge clk);
        drive(s16, 1'b1, d, amt, lr, md, 1'b1);
        #1;
        while (!in_rdy(s16) && w < 20) begin
            @(negedge clk); #1; w++;
        end
        if (!in_rdy(s16)) begin
            drive(s16, 1'b0, '0, 0, 1'b0, 2'b00, 1'b1);
            return;
        end
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            drive(s16, 1'b0, '0, 0, 1'b0, 2'b00, 1'b1);
            #1;
            if (out_vld(s16)) begin
                lat = n;
                res = out_dat(s16);
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 0, 1'b0, 2'b00, 1'b0);
        drive(1'b1, 1'b0, '0, 0, 1'b0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({if32.out_valid, if32.busy, if32.in_ready} !== 3'b000) begin errors++;
            $display("FAIL reset_ctrl32: observed %b required 000", {if32.out_valid, if32.busy, if32.in_ready}); end
        checks++; if (if32.data_out !== 32'h0) begin errors++;
            $display("FAIL reset_data32: observed %h required 00000000", if32.data_out); end
        checks++; if ({if16.out_valid, if16.busy, if16.in_ready, if16.data_out} !== 19'h0) begin errors++;
            $display("FAIL reset_16: observed %h required 0", {if16.out_valid, if16.busy, if16.in_ready, if16.data_out}); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (if32.in_ready !== 1'b1) begin errors++;
            $display("FAIL ready_after_reset: observed %b required 1", if32.in_ready); end
    endtask

    task automatic test_logical_left();
        logic [31:0] din [4] = '{32'h0000_00F1, 32'h0000_00F1, 32'h0000_00F1, 32'h0000_00F1};
        int          amt [4] = '{4, 0, 0, 0};
        logic        lr  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0]  md  [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
        logic [31:0] exp [4] = '{32'h0000_0F10, 32'h0000_00F1, 32'h0000_00F1, 32'h0000_00F1};
        int lat; logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, din[i], amt[i], lr[i], md[i], lat, res);
            checks++; if (lat !== 5) begin errors++;
                $display("FAIL left_latency[%0d]: observed %0d required 5", i, lat); end
            checks++; if (res !== exp[i]) begin errors++;
                $display("FAIL left_data[%0d]: observed %h required %h", i, res, exp[i]); end
        end
    endtask

    task automatic test_right_shifts();
        logic [31:0] din [3] = '{32'h8000_0000, 32'h8000_0000, 32'h7000_0000};
        int          amt [3] = '{31, 31, 4};
        logic [1:0]  md  [3] = '{2'b01, 2'b00, 2'b01};
        logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0700_0000};
        int lat; logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, din[i], amt[i], 1'b0, md[i], lat, res);
            checks++; if (lat !== 5 || res !== exp[i]) begin errors++;
                $display("FAIL right[%0d]: observed %h lat %0d required %h lat 5", i, res, lat, exp[i]); end
        end
    endtask

    task automatic test_rotates();
        logic [31:0] din [3] = '{32'h0000_0001, 32'h8000_0001, 32'h0000_0001};
        int          amt [3] = '{1, 1, 3};
        logic        lr  [3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0]  md  [3] = '{2'b10, 2'b10, 2'b11};
        logic [31:0] exp [3] = '{32'h8000_0000, 32'h0000_0003, 32'h0000_0008};
        int lat; logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, din[i], amt[i], lr[i], md[i], lat, res);
            checks++; if (lat !== 5 || res !== exp[i]) begin errors++;
                $display("FAIL rotate[%0d]: observed %h lat %0d required %h lat 5", i, res, lat, exp[i]); end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] got [$];
        logic [31:0] held;
        bit seen, stable;
        int idx, c, first_c, last_c;
        idx = 0; seen = 0; stable = 1; held = '0;
        for (int cy = 0; cy < 12; cy++) begin
            @(negedge clk);
            if (idx < 8) drive(1'b0, 1'b1, 32'(idx + 1), 1, 1'b1, 2'b00, 1'b0);
            else         drive(1'b0, 1'b0, '0, 0, 1'b0, 2'b00, 1'b0);
            #1;
            if (if32.out_valid) begin
                if (!seen) begin held = if32.data_out; seen = 1; end
                else if (if32.data_out !== held) stable = 0;
            end
            if (if32.in_valid && if32.in_ready) idx++;
        end
        checks++; if (idx !== 5) begin errors++;
            $display("FAIL bp_accepted: observed %0d required 5", idx); end
        checks++; if (if32.in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_in_ready: observed %b required 0", if32.in_ready); end
        checks++; if (!(seen && stable && held === 32'd2)) begin errors++;
            $display("FAIL bp_hold: observed seen %0d stable %0d data %h required 1 1 00000002", seen, stable, held); end
        c = 0; first_c = -1; last_c = -1;
        while (got.size() < 8 && c < 40) begin
            @(negedge clk);
            if (idx < 8) drive(1'b0, 1'b1, 32'(idx + 1), 1, 1'b1, 2'b00, 1'b1);
            else         drive(1'b0, 1'b0, '0, 0, 1'b0, 2'b00, 1'b1);
            #1;
            if (if32.out_valid && if32.out_ready) begin
                got.push_back(if32.data_out);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (if32.in_valid && if32.in_ready) idx++;
            c++;
        end
        checks++; if (got.size() !== 8) begin errors++;
            $display("FAIL bp_count: observed %0d required 8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 32'(2 * (i + 1))) begin errors++;
                $display("FAIL bp_order[%0d]: observed %h required %h", i, got[i], 32'(2 * (i + 1))); end
        end
        checks++; if (last_c - first_c !== 7) begin errors++;
            $display("FAIL bp_rate: observed span %0d required 7", last_c - first_c); end
        checks++; if (if32.busy !== 1'b1) begin errors++;
            $display("FAIL bp_busy_last: observed %b required 1", if32.busy); end
        @(negedge clk);
        #1;
        checks++; if ({if32.busy, if32.out_valid} !== 2'b00) begin errors++;
            $display("FAIL bp_busy_fall: observed %b required 00", {if32.busy, if32.out_valid}); end
    endtask

    task automatic test_reset_midstream();
        int acc, c, ghosts, lat;
        logic [31:0] res;
        acc = 0; c = 0; ghosts = 0;
        while (acc < 3 && c < 10) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 32'h0000_0111 * 32'(acc + 1), 0, 1'b1, 2'b00, 1'b1);
            #1;
            if (if32.in_ready) acc++;
            c++;
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 0, 1'b0, 2'b00, 1'b1);
        reset = 1'b1;
        #1;
        checks++; if (if32.in_ready !== 1'b0) begin errors++;
            $display("FAIL mid_in_ready: observed %b required 0", if32.in_ready); end
        @(negedge clk);
        #1;
        checks++; if ({if32.out_valid, if32.busy, if32.in_ready, if32.data_out} !== 35'h0) begin errors++;
            $display("FAIL mid_reset_state: observed %h required 0", {if32.out_valid, if32.busy, if32.in_ready, if32.data_out}); end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (if32.out_valid) ghosts++;
        end
        checks++; if (ghosts !== 0) begin errors++;
            $display("FAIL mid_ghosts: observed %0d required 0", ghosts); end
        xfer(1'b0, 32'h1234_5678, 8, 1'b1, 2'b00, lat, res);
        checks++; if (lat !== 5 || res !== 32'h3456_7800) begin errors++;
            $display("FAIL mid_after: observed %h lat %0d required 34567800 lat 5", res, lat); end
    endtask

    task automatic test_alt_config();
        int lat; logic [31:0] res;
        xfer(1'b1, 32'h0000_A5A5, 4, 1'b0, 2'b10, lat, res);
        checks++; if (lat !== 1 || res !== 32'h0000_5A5A) begin errors++;
            $display("FAIL alt_rotate: observed %h lat %0d required 00005a5a lat 1", res, lat); end
        xfer(1'b1, 32'h0000_8000, 15, 1'b0, 2'b01, lat, res);
        checks++; if (lat !== 1 || res !== 32'h0000_FFFF) begin errors++;
            $display("FAIL alt_arith: observed %h lat %0d required 0000ffff lat 1", res, lat); end
    endtask

    task automatic test_random_stream(input bit s16, input int nbeats);
        logic [31:0] expq [$];
        logic [63:0] r64;
        logic [31:0] d, e, prev_data;
        logic        lr, v, ordy, prev_stall;
        logic [1:0]  md;
        int w, amt, sent, recv, cyc, bad;
        w = s16 ? 16 : 32;
        sent = 0; recv = 0; cyc = 0; bad = 0;
        prev_stall = 1'b0; prev_data = '0;
        while (recv < nbeats && cyc < 20000) begin
            @(negedge clk);
            d    = $urandom;
            amt  = $urandom_range(0, w - 1);
            lr   = 1'($urandom_range(0, 1));
            md   = 2'($urandom_range(0, 3));
            v    = (sent < nbeats) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            drive(s16, v, d, amt, lr, md, ordy);
            #1;
            if (prev_stall) begin
                checks++; if (!out_vld(s16) || out_dat(s16) !== prev_data) begin errors++;
                    $display("FAIL rnd_stall_hold(%0d): observed %b/%h required 1/%h", w, out_vld(s16), out_dat(s16), prev_data); end
            end
            prev_stall = out_vld(s16) && !ordy;
            prev_data  = out_dat(s16);
            if (out_vld(s16) && ordy) begin
                e = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF;
                checks++; if (out_dat(s16) !== e) begin errors++;
                    if (bad < 10) $display("FAIL rnd_data(%0d)[%0d]: observed %h required %h", w, recv, out_dat(s16), e);
                    bad++; end
                recv++;
            end
            if (v && in_rdy(s16)) begin
                r64 = ref_shift(w, {32'h0, d}, amt, lr, md);
                expq.push_back(r64[31:0]);
                sent++;
            end
            cyc++;
        end
        drive(s16, 1'b0, '0, 0, 1'b0, 2'b00, 1'b1);
        checks++; if (recv !== nbeats) begin errors++;
            $display("FAIL rnd_count(%0d): observed %0d required %0d", w, recv, nbeats); end
    endtask

    initial begin
        test_reset();
        test_logical_left();
        test_right_shifts();
        test_rotates();
        test_back_pressure();
        test_reset_midstream();
        test_alt_config();
        test_random_stream(1'b1, 1000);
        test_random_stream(1'b0, 500);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
